// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bundle for alu_issue_ctrl: decoded instruction handshake, ALU operand/result
// wiring and the downstream result handshake. The controller uses the slave modport.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             Valid_in;
    logic             Ready_out;
    logic [5:0]       Op_in;
    logic [5:0]       Funct_in;
    logic [4:0]       Rt_num_in;
    logic [4:0]       Rs_num_in;
    logic [4:0]       Dst_num_in;
    logic [WIDTH-1:0] Rs_val_in;
    logic [WIDTH-1:0] Rt_val_in;
    logic [15:0]      Imm_in;
    logic [WIDTH-1:0] PC_in;
    logic [5:0]       Func_out;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic [WIDTH-1:0] O_in;
    logic             Branch_in;
    logic             Res_valid_out;
    logic             Res_ready_in;
    logic [WIDTH-1:0] Res_out;
    logic             Taken_out;
    logic [WIDTH-1:0] Target_out;
    logic             Flush_out;
    logic             Illegal_out;

    modport master (
        output Valid_in, Op_in, Funct_in, Rt_num_in, Rs_num_in, Dst_num_in,
               Rs_val_in, Rt_val_in, Imm_in, PC_in, O_in, Branch_in, Res_ready_in,
        input  Ready_out, Func_out, A_out, B_out, Res_valid_out, Res_out,
               Taken_out, Target_out, Flush_out, Illegal_out
    );

    modport slave (
        input  Valid_in, Op_in, Funct_in, Rt_num_in, Rs_num_in, Dst_num_in,
               Rs_val_in, Rt_val_in, Imm_in, PC_in, O_in, Branch_in, Res_ready_in,
        output Ready_out, Func_out, A_out, B_out, Res_valid_out, Res_out,
               Taken_out, Target_out, Flush_out, Illegal_out
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes op/funct to the ALU function code, registers
// operands, captures the ALU result and branch outcome. Optional operand forwarding: ALU_ISSUE_FWD_EN.
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            Clk_in,
    input  logic            Rst_n_in,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic             ready_reg;
    logic [5:0]       func_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             branch_reg;
    logic             illegal_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] res_reg;
    logic             res_valid_reg;
    logic             taken_reg;
    logic             flush_reg;

    logic [5:0]       func_next;
    logic             use_imm_next;
    logic             branch_next;
    logic             illegal_next;
    logic [WIDTH-1:0] sext_imm;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] target_next;
    logic             accept;
    logic             taken_now;

    assign accept    = (state_reg == IDLE) && bus.Valid_in && ready_reg;
    assign sext_imm  = {{(WIDTH-16){bus.Imm_in[15]}}, bus.Imm_in};
    assign taken_now = branch_reg & bus.Branch_in & ~illegal_reg;
    // Wraps modulo 2^WIDTH by construction.
    assign target_next = bus.PC_in + WIDTH'(4) + (sext_imm << 2);

    always_comb begin
        func_next    = 6'b100001;
        use_imm_next = 1'b0;
        branch_next  = 1'b0;
        illegal_next = 1'b0;
        case (bus.Op_in)
            6'b000000: func_next = bus.Funct_in;
            6'b001000: begin func_next = 6'b100000; use_imm_next = 1'b1; end
            6'b001001: begin func_next = 6'b100001; use_imm_next = 1'b1; end
            6'b000100: begin func_next = 6'b111100; branch_next = 1'b1; end
            6'b000101: begin func_next = 6'b111101; branch_next = 1'b1; end
            6'b000110: begin func_next = 6'b111110; branch_next = 1'b1; end
            6'b000111: begin func_next = 6'b111111; branch_next = 1'b1; end
            6'b000001: begin
                if (bus.Rt_num_in == 5'd0) begin
                    func_next   = 6'b111000;
                    branch_next = 1'b1;
                end else if (bus.Rt_num_in == 5'd1) begin
                    func_next   = 6'b111001;
                    branch_next = 1'b1;
                end else begin
                    illegal_next = 1'b1;
                end
            end
            default: illegal_next = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    logic             fwd_valid_reg;
    logic [4:0]       fwd_dst_reg;
    logic [WIDTH-1:0] fwd_val_reg;
    logic [4:0]       dst_reg;
    logic             fwd_rs_hit;
    logic             fwd_rt_hit;

    assign fwd_rs_hit = fwd_valid_reg && (fwd_dst_reg != 5'd0) && (bus.Rs_num_in == fwd_dst_reg);
    assign fwd_rt_hit = fwd_valid_reg && (fwd_dst_reg != 5'd0) && (bus.Rt_num_in == fwd_dst_reg);

    always_comb begin
        a_next = fwd_rs_hit ? fwd_val_reg : bus.Rs_val_in;
        if (use_imm_next)
            b_next = sext_imm;
        else
            b_next = fwd_rt_hit ? fwd_val_reg : bus.Rt_val_in;
    end

    // Only plain ALU results become forwarding entries; branches and illegal ops leave it as is.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            fwd_valid_reg <= 1'b0;
            fwd_dst_reg   <= 5'd0;
            fwd_val_reg   <= '0;
            dst_reg       <= 5'd0;
        end else begin
            if (accept)
                dst_reg <= bus.Dst_num_in;
            if (state_reg == EXEC && !branch_reg && !illegal_reg) begin
                fwd_valid_reg <= 1'b1;
                fwd_dst_reg   <= dst_reg;
                fwd_val_reg   <= bus.O_in;
            end
        end
    end
`else
    always_comb begin
        a_next = bus.Rs_val_in;
        b_next = use_imm_next ? sext_imm : bus.Rt_val_in;
    end
`endif

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            func_reg      <= 6'd0;
            a_reg         <= '0;
            b_reg         <= '0;
            branch_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
            target_reg    <= '0;
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
            taken_reg     <= 1'b0;
            flush_reg     <= 1'b0;
        end else begin
            flush_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        func_reg    <= func_next;
                        a_reg       <= a_next;
                        b_reg       <= b_next;
                        branch_reg  <= branch_next;
                        illegal_reg <= illegal_next;
                        target_reg  <= target_next;
                        ready_reg   <= 1'b0;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    res_reg       <= bus.O_in;
                    taken_reg     <= taken_now;
                    flush_reg     <= taken_now;
                    res_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (bus.Res_ready_in) begin
                        res_valid_reg <= 1'b0;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ready_out     = ready_reg;
    assign bus.Func_out      = func_reg;
    assign bus.A_out         = a_reg;
    assign bus.B_out         = b_reg;
    assign bus.Res_out       = res_reg;
    assign bus.Res_valid_out = res_valid_reg;
    assign bus.Taken_out     = taken_reg;
    assign bus.Target_out    = target_reg;
    assign bus.Flush_out     = flush_reg;
    assign bus.Illegal_out   = illegal_reg;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a small behavioural ALU on the operand side.
// Forwarding expectations follow ALU_ISSUE_FWD_EN when it is defined for the build.
module tb_alu_issue_ctrl;
    logic Clk_in   = 1'b0;
    logic Rst_n_in = 1'b0;
    logic force_br = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .Clk_in   (Clk_in),
        .Rst_n_in (Rst_n_in),
        .bus      (bus)
    );

    always #5 Clk_in = ~Clk_in;

    // Behavioural ALU; force_br lets a test drive Branch_in high regardless of the function.
    always_comb begin
        bus.O_in      = 32'd0;
        bus.Branch_in = 1'b0;
        case (bus.Func_out)
            6'b100000, 6'b100001: bus.O_in = bus.A_out + bus.B_out;
            6'b111000: bus.Branch_in = bus.A_out[31];
            6'b111001: bus.Branch_in = !bus.A_out[31];
            6'b111100: bus.Branch_in = (bus.A_out == bus.B_out);
            6'b111101: bus.Branch_in = (bus.A_out != bus.B_out);
            6'b111110: bus.Branch_in = bus.A_out[31] || (bus.A_out == 32'd0);
            6'b111111: bus.Branch_in = !bus.A_out[31] && (bus.A_out != 32'd0);
            default:   bus.O_in = 32'd0;
        endcase
        if (force_br)
            bus.Branch_in = 1'b1;
    end

    task automatic tick();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt_num,
                         input logic [4:0] rs_num, input logic [4:0] dst,
                         input logic [31:0] rs_val, input logic [31:0] rt_val,
                         input logic [15:0] imm, input logic [31:0] pc);
        bus.Op_in      = op;
        bus.Funct_in   = funct;
        bus.Rt_num_in  = rt_num;
        bus.Rs_num_in  = rs_num;
        bus.Dst_num_in = dst;
        bus.Rs_val_in  = rs_val;
        bus.Rt_val_in  = rt_val;
        bus.Imm_in     = imm;
        bus.PC_in      = pc;
        bus.Valid_in   = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if ({bus.Ready_out, bus.Res_valid_out, bus.Taken_out, bus.Flush_out, bus.Illegal_out} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 10000",
                     {bus.Ready_out, bus.Res_valid_out, bus.Taken_out, bus.Flush_out, bus.Illegal_out});
        end
        tests_run++;
        if ({bus.Func_out, bus.A_out, bus.B_out, bus.Res_out, bus.Target_out} !== 134'd0) begin
            tests_failed++;
            $display("FAIL reset_data: func=%b a=%h b=%h res=%h tgt=%h, expected all zero",
                     bus.Func_out, bus.A_out, bus.B_out, bus.Res_out, bus.Target_out);
        end
        Rst_n_in = 1'b1;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_addu();
        bus.Res_ready_in = 1'b1;
        drive(6'b000000, 6'b100001, 5'd0, 5'd0, 5'd0, 32'h0000_0001, 32'hFFFF_FFFE, 16'h0000, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tests_run++;
        if ({bus.Ready_out, bus.Res_valid_out, bus.Func_out, bus.A_out, bus.B_out} !==
            {1'b0, 1'b0, 6'b100001, 32'h0000_0001, 32'hFFFF_FFFE}) begin
            tests_failed++;
            $display("FAIL addu_issue: rdy=%b vld=%b func=%b a=%h b=%h, expected 0 0 100001 00000001 fffffffe",
                     bus.Ready_out, bus.Res_valid_out, bus.Func_out, bus.A_out, bus.B_out);
        end
        tick();
        tests_run++;
        if ({bus.Res_valid_out, bus.Res_out, bus.Taken_out, bus.Flush_out, bus.Illegal_out} !==
            {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL addu_result: vld=%b res=%h taken=%b flush=%b ill=%b, expected 1 ffffffff 0 0 0",
                     bus.Res_valid_out, bus.Res_out, bus.Taken_out, bus.Flush_out, bus.Illegal_out);
        end
        tick();
        tests_run++;
        if ({bus.Res_valid_out, bus.Ready_out, bus.Flush_out} !== 3'b010) begin
            tests_failed++;
            $display("FAIL addu_release: vld/rdy/flush=%b, expected 010",
                     {bus.Res_valid_out, bus.Ready_out, bus.Flush_out});
        end
        $display("[TB] ADDU 00000001+fffffffe res=%h", bus.Res_out);
    endtask

    task automatic test_addi_neg();
        drive(6'b001000, 6'b000000, 5'd0, 5'd0, 5'd0, 32'h0000_0010, 32'h1234_5678, 16'hFFFE, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tests_run++;
        if ({bus.Func_out, bus.B_out} !== {6'b100000, 32'hFFFF_FFFE}) begin
            tests_failed++;
            $display("FAIL addi_issue: func=%b b=%h, expected 100000 fffffffe", bus.Func_out, bus.B_out);
        end
        tick();
        tests_run++;
        if (bus.Res_out !== 32'h0000_000E) begin
            tests_failed++;
            $display("FAIL addi_result: res=%h, expected 0000000e", bus.Res_out);
        end
        tick();
        $display("[TB] ADDI 00000010+sext(fffe) res=%h", bus.Res_out);
    endtask

    task automatic test_bltz();
        drive(6'b000001, 6'b000000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 16'h0003, 32'h0000_0100);
        tick();
        bus.Valid_in = 1'b0;
        tests_run++;
        if ({bus.Func_out, bus.Flush_out} !== {6'b111000, 1'b0}) begin
            tests_failed++;
            $display("FAIL bltz_issue: func=%b flush=%b, expected 111000 0", bus.Func_out, bus.Flush_out);
        end
        tick();
        tests_run++;
        if ({bus.Taken_out, bus.Flush_out, bus.Target_out, bus.Res_valid_out} !==
            {1'b1, 1'b1, 32'h0000_0110, 1'b1}) begin
            tests_failed++;
            $display("FAIL bltz_result: taken=%b flush=%b tgt=%h vld=%b, expected 1 1 00000110 1",
                     bus.Taken_out, bus.Flush_out, bus.Target_out, bus.Res_valid_out);
        end
        tick();
        tests_run++;
        if (bus.Flush_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL bltz_flush_width: flush=%b, expected 0", bus.Flush_out);
        end
        $display("[TB] BLTZ pc=00000100 imm=0003 target=%h", bus.Target_out);
    endtask

    task automatic test_beq();
        drive(6'b000100, 6'b000000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1, 16'hFFFF, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        tests_run++;
        if ({bus.Taken_out, bus.Flush_out} !== 2'b00) begin
            tests_failed++;
            $display("FAIL beq_not_taken: taken/flush=%b, expected 00", {bus.Taken_out, bus.Flush_out});
        end
        tick();
        $display("[TB] BEQ 0 vs 1 taken=%b", bus.Taken_out);
        // Taken branch whose target wraps past the top of the address space.
        drive(6'b000100, 6'b000000, 5'd0, 5'd0, 5'd0, 32'h5, 32'h5, 16'h0000, 32'hFFFF_FFFC);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        tests_run++;
        if ({bus.Taken_out, bus.Flush_out, bus.Target_out} !== {1'b1, 1'b1, 32'h0000_0000}) begin
            tests_failed++;
            $display("FAIL beq_wrap: taken=%b flush=%b tgt=%h, expected 1 1 00000000",
                     bus.Taken_out, bus.Flush_out, bus.Target_out);
        end
        tick();
        $display("[TB] BEQ pc=fffffffc wrap target=%h", bus.Target_out);
    endtask

    task automatic test_illegal();
        force_br = 1'b1;
        drive(6'b111111, 6'b000000, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 16'h0000, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        tests_run++;
        if ({bus.Illegal_out, bus.Func_out, bus.Taken_out, bus.Flush_out} !== {1'b1, 6'b100001, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_op: ill=%b func=%b taken=%b flush=%b, expected 1 100001 0 0",
                     bus.Illegal_out, bus.Func_out, bus.Taken_out, bus.Flush_out);
        end
        tick();
        drive(6'b000001, 6'b000000, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 16'h0000, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        tests_run++;
        if ({bus.Illegal_out, bus.Func_out, bus.Taken_out} !== {1'b1, 6'b100001, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_regimm: ill=%b func=%b taken=%b, expected 1 100001 0",
                     bus.Illegal_out, bus.Func_out, bus.Taken_out);
        end
        tick();
        force_br = 1'b0;
        $display("[TB] illegal op and REGIMM rt=2 ill=%b", bus.Illegal_out);
    endtask

    task automatic test_backpressure();
        bit bad = 1'b0;
        bus.Res_ready_in = 1'b0;
        drive(6'b000000, 6'b100001, 5'd0, 5'd0, 5'd0, 32'h3, 32'h4, 16'h0000, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 6'b100001, 5'd0, 5'd0, 5'd0, 32'hAA, 32'hBB, 16'h0000, 32'h0);
            if ({bus.Res_valid_out, bus.Res_out, bus.Ready_out, bus.A_out} !== {1'b1, 32'h7, 1'b0, 32'h3})
                bad = 1'b1;
            tick();
        end
        tests_run++;
        if (bad || {bus.Res_valid_out, bus.Res_out, bus.Ready_out, bus.A_out} !== {1'b1, 32'h7, 1'b0, 32'h3}) begin
            tests_failed++;
            $display("FAIL backpressure_hold: vld=%b res=%h rdy=%b a=%h, expected 1 00000007 0 00000003 throughout",
                     bus.Res_valid_out, bus.Res_out, bus.Ready_out, bus.A_out);
        end
        bus.Valid_in     = 1'b0;
        bus.Res_ready_in = 1'b1;
        tick();
        tests_run++;
        if ({bus.Res_valid_out, bus.Ready_out, bus.A_out} !== {1'b0, 1'b1, 32'h3}) begin
            tests_failed++;
            $display("FAIL backpressure_release: vld=%b rdy=%b a=%h, expected 0 1 00000003",
                     bus.Res_valid_out, bus.Ready_out, bus.A_out);
        end
        $display("[TB] backpressure 5 cycles res=%h", bus.Res_out);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        bus.Res_ready_in = 1'b1;
        drive(6'b000000, 6'b100001, 5'd0, 5'd0, 5'd0, 32'h1, 32'h1, 16'h0000, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (bus.Ready_out === 1'b1)
                accepts++;
            tick();
        end
        bus.Valid_in = 1'b0;
        tests_run++;
        if (accepts != 3) begin
            tests_failed++;
            $display("FAIL back_to_back: %0d accepts in 9 cycles, expected 3", accepts);
        end
        tick();
        tick();
        $display("[TB] back-to-back accepts=%0d", accepts);
    endtask

    task automatic test_reset_mid_exec();
        bit bad = 1'b0;
        drive(6'b000001, 6'b000000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h9, 16'h0003, 32'h0000_0100);
        tick();
        bus.Valid_in = 1'b0;
        Rst_n_in = 1'b0;
        #1;
        tests_run++;
        if ({bus.Func_out, bus.A_out, bus.B_out, bus.Res_out, bus.Target_out,
             bus.Res_valid_out, bus.Taken_out, bus.Flush_out, bus.Illegal_out, bus.Ready_out} !== {134'd0, 5'b00001}) begin
            tests_failed++;
            $display("FAIL reset_exec_async: func=%b a=%h b=%h tgt=%h vld=%b rdy=%b, expected zeros and rdy=1",
                     bus.Func_out, bus.A_out, bus.B_out, bus.Target_out, bus.Res_valid_out, bus.Ready_out);
        end
        @(negedge Clk_in);
        Rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({bus.Res_valid_out, bus.Flush_out, bus.Ready_out} !== 3'b001)
                bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL reset_exec_after: vld/flush/rdy=%b, expected 001 each cycle",
                     {bus.Res_valid_out, bus.Flush_out, bus.Ready_out});
        end
        $display("[TB] reset in EXEC discarded result");
    endtask

    task automatic test_forward();
        logic [31:0] exp_a;
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'h0000_0011;
`else
        exp_a = 32'h0000_0000;
`endif
        drive(6'b001001, 6'b000000, 5'd0, 5'd10, 5'd5, 32'h0000_0010, 32'h0, 16'h0001, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tick();
        tests_run++;
        if (bus.Res_out !== 32'h0000_0011) begin
            tests_failed++;
            $display("FAIL fwd_producer: res=%h, expected 00000011", bus.Res_out);
        end
        tick();
        drive(6'b000000, 6'b100001, 5'd0, 5'd5, 5'd6, 32'h0, 32'h2, 16'h0000, 32'h0);
        tick();
        bus.Valid_in = 1'b0;
        tests_run++;
        if (bus.A_out !== exp_a) begin
            tests_failed++;
            $display("FAIL fwd_consumer_a: a=%h, expected %h", bus.A_out, exp_a);
        end
        tick();
        tests_run++;
        if (bus.Res_out !== exp_a + 32'h2) begin
            tests_failed++;
            $display("FAIL fwd_consumer_res: res=%h, expected %h", bus.Res_out, exp_a + 32'h2);
        end
        tick();
        $display("[TB] forwarding consumer A=%h", bus.A_out);
    endtask

    initial begin
        bus.Valid_in     = 1'b0;
        bus.Res_ready_in = 1'b1;
        bus.Op_in        = 6'd0;
        bus.Funct_in     = 6'd0;
        bus.Rt_num_in    = 5'd0;
        bus.Rs_num_in    = 5'd0;
        bus.Dst_num_in   = 5'd0;
        bus.Rs_val_in    = 32'd0;
        bus.Rt_val_in    = 32'd0;
        bus.Imm_in       = 16'd0;
        bus.PC_in        = 32'd0;
        test_reset();
        test_addu();
        test_addi_neg();
        test_bltz();
        test_beq();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_forward();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
